// File: rtl/id_ex_pipe.sv
// ID/EX pipeline stage: a main register plus one skid register, with ready registered from skid occupancy.
// Optional build macro ID_EX_FWD_INFO_EN carries the rs1/rs2 source addresses alongside rd for forwarding.
module id_ex_pipe #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              RegWrite_i,
  input  logic              ALUSrc_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [9:0]        funct_i,
  input  logic [4:0]        rd_i,
`ifdef ID_EX_FWD_INFO_EN
  input  logic [4:0]        rs1_addr_i,
  input  logic [4:0]        rs2_addr_i,
  output logic [4:0]        rs1_addr_o,
  output logic [4:0]        rs2_addr_o,
`endif
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              RegWrite_o,
  output logic              ALUSrc_o,
  output logic [1:0]        ALUOp_o,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic [DATA_W-1:0] imm_o,
  output logic [9:0]        funct_o,
  output logic [4:0]        rd_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [1:0]        state_o
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

`ifdef ID_EX_FWD_INFO_EN
  localparam int BW = 4 + 3 * DATA_W + 15 + 10;
`else
  localparam int BW = 4 + 3 * DATA_W + 15;
`endif

  // Handshake: a bundle moves on any rising edge where valid and ready are both high;
  // the producer holds a valid bundle stable until it moves.
  logic [1:0]       r_state;
  logic [BW-1:0]    r_main;
  logic [BW-1:0]    r_skid;
  logic [CNT_W-1:0] r_stall;
  logic [BW-1:0]    w_in;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_rw;

`ifdef ID_EX_FWD_INFO_EN
  assign w_in = {RegWrite_i, ALUSrc_i, ALUOp_i, rs1_data_i, rs2_data_i, imm_i, funct_i, rd_i,
                 rs1_addr_i, rs2_addr_i};
  assign {w_main_rw, ALUSrc_o, ALUOp_o, rs1_data_o, rs2_data_o, imm_o, funct_o, rd_o,
          rs1_addr_o, rs2_addr_o} = r_main;
`else
  assign w_in = {RegWrite_i, ALUSrc_i, ALUOp_i, rs1_data_i, rs2_data_i, imm_i, funct_i, rd_i};
  assign {w_main_rw, ALUSrc_o, ALUOp_o, rs1_data_o, rs2_data_o, imm_o, funct_o, rd_o} = r_main;
`endif

  // Ready depends only on the state register, so out_ready_i never reaches in_ready_o.
  assign in_ready_o  = (r_state != S_FULL);
  assign out_valid_o = (r_state != S_EMPTY);
  assign w_in_xfer   = in_valid_i && in_ready_o;
  assign w_out_xfer  = out_valid_o && out_ready_i;
  assign RegWrite_o  = w_main_rw && out_valid_o;
  assign stall_cnt_o = r_stall;
  assign state_o     = r_state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush_i) begin
      // Data stays in main so outputs hold their last contents while invalid.
      r_state <= S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_main  <= w_in;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_main <= w_in;
          end else if (w_in_xfer) begin
            r_skid  <= w_in;
            r_state <= S_FULL;
          end else if (w_out_xfer) begin
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_xfer) begin
            r_main  <= r_skid;
            r_state <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall <= '0;
    end else if (out_valid_o && !out_ready_i && (r_stall != {CNT_W{1'b1}})) begin
      r_stall <= r_stall + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: reset, latency, skid ordering, streaming, flush, stall saturation, reset while full.
// Build with ID_EX_FWD_INFO_EN defined to also carry and check the forwarding addresses.
module tb_id_ex_pipe;
  localparam int DW = 32;
  localparam int CW = 4;
`ifdef ID_EX_FWD_INFO_EN
  localparam int BW = 4 + 3 * DW + 15 + 10;
  localparam int RD_LSB = 10;
`else
  localparam int BW = 4 + 3 * DW + 15;
  localparam int RD_LSB = 0;
`endif

  logic          clk;
  logic          rst_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic          RegWrite_i;
  logic          ALUSrc_i;
  logic [1:0]    ALUOp_i;
  logic [DW-1:0] rs1_data_i;
  logic [DW-1:0] rs2_data_i;
  logic [DW-1:0] imm_i;
  logic [9:0]    funct_i;
  logic [4:0]    rd_i;
`ifdef ID_EX_FWD_INFO_EN
  logic [4:0]    rs1_addr_i;
  logic [4:0]    rs2_addr_i;
  logic [4:0]    rs1_addr_o;
  logic [4:0]    rs2_addr_o;
`endif
  logic          flush_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          RegWrite_o;
  logic          ALUSrc_o;
  logic [1:0]    ALUOp_o;
  logic [DW-1:0] rs1_data_o;
  logic [DW-1:0] rs2_data_o;
  logic [DW-1:0] imm_o;
  logic [9:0]    funct_o;
  logic [4:0]    rd_o;
  logic [CW-1:0] stall_cnt_o;
  logic [1:0]    state_o;

  int n_vec = 0;
  int n_err = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] w_obs;
  logic [BW-1:0] e;

`ifdef ID_EX_FWD_INFO_EN
  assign w_obs = {RegWrite_o, ALUSrc_o, ALUOp_o, rs1_data_o, rs2_data_o, imm_o, funct_o, rd_o,
                  rs1_addr_o, rs2_addr_o};
`else
  assign w_obs = {RegWrite_o, ALUSrc_o, ALUOp_o, rs1_data_o, rs2_data_o, imm_o, funct_o, rd_o};
`endif

  id_ex_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .RegWrite_i(RegWrite_i), .ALUSrc_i(ALUSrc_i), .ALUOp_i(ALUOp_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .funct_i(funct_i), .rd_i(rd_i),
`ifdef ID_EX_FWD_INFO_EN
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
`endif
    .flush_i(flush_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .RegWrite_o(RegWrite_o), .ALUSrc_o(ALUSrc_o), .ALUOp_o(ALUOp_o),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
    .funct_o(funct_o), .rd_o(rd_o), .stall_cnt_o(stall_cnt_o), .state_o(state_o)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: bundle fields are a fixed function of an index k.
  task automatic set_in(input int k);
    logic [31:0] kk;
    kk = k;
    RegWrite_i = kk[0];
    ALUSrc_i   = kk[1];
    ALUOp_i    = kk[3:2];
    rs1_data_i = 32'h1000_0000 + kk;
    rs2_data_i = 32'hA5A5_0000 ^ kk;
    imm_i      = ~kk;
    funct_i    = kk[9:0] ^ 10'h155;
    rd_i       = kk[4:0] ^ 5'h0A;
`ifdef ID_EX_FWD_INFO_EN
    rs1_addr_i = kk[8:4];
    rs2_addr_i = kk[9:5];
`endif
  endtask

  function automatic logic [BW-1:0] exp_of(input int k);
    logic [31:0] kk;
    kk = k;
`ifdef ID_EX_FWD_INFO_EN
    return {kk[0], kk[1], kk[3:2], 32'h1000_0000 + kk, 32'hA5A5_0000 ^ kk, ~kk,
            kk[9:0] ^ 10'h155, kk[4:0] ^ 5'h0A, kk[8:4], kk[9:5]};
`else
    return {kk[0], kk[1], kk[3:2], 32'h1000_0000 + kk, 32'hA5A5_0000 ^ kk, ~kk,
            kk[9:0] ^ 10'h155, kk[4:0] ^ 5'h0A};
`endif
  endfunction

  initial begin
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0;
    set_in(0);
    tick(); tick();
    chk("rst_out_valid", 128'(out_valid_o), 128'(0));
    chk("rst_outputs", 128'(w_obs), 128'(0));
    chk("rst_stall", 128'(stall_cnt_o), 128'(0));
    chk("rst_state", 128'(state_o), 128'(0));
    rst_i = 1'b0;
    chk("ready_after_rst", 128'(in_ready_o), 128'(1));

    // Single bundle, latency 1
    RegWrite_i = 1'b1; ALUSrc_i = 1'b0; ALUOp_i = 2'b10; rs1_data_i = 32'h11;
    rs2_data_i = 32'h22; imm_i = 32'hFFFF_FFF0; funct_i = 10'h020; rd_i = 5'd5;
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("t1_valid", 128'(out_valid_o), 128'(1));
    chk("t1_regwrite", 128'(RegWrite_o), 128'(1));
    chk("t1_aluop", 128'(ALUOp_o), 128'(2'b10));
    chk("t1_rd", 128'(rd_o), 128'(5));
    chk("t1_imm", 128'(imm_o), 128'(32'hFFFF_FFF0));
    tick();
    chk("t1_valid_drop", 128'(out_valid_o), 128'(0));
    chk("t1_regwrite_forced0", 128'(RegWrite_o), 128'(0));
    chk("t1_rd_hold", 128'(rd_o), 128'(5));

    // Back-pressure: A then B fill main and skid
    out_ready_i = 1'b0; set_in(1); in_valid_i = 1'b1;
    tick();
    chk("t2_state_one", 128'(state_o), 128'(1));
    chk("t2_ready_one", 128'(in_ready_o), 128'(1));
    chk("t2_stall0", 128'(stall_cnt_o), 128'(0));
    set_in(2);
    tick();
    in_valid_i = 1'b0;
    chk("t2_ready_full", 128'(in_ready_o), 128'(0));
    chk("t2_stall1", 128'(stall_cnt_o), 128'(1));
    chk("t2_hold_a", 128'(w_obs), 128'(exp_of(1)));
    tick();
    chk("t2_stall2", 128'(stall_cnt_o), 128'(2));
    tick();
    chk("t2_stall3", 128'(stall_cnt_o), 128'(3));
    chk("t2_stable_a", 128'(w_obs), 128'(exp_of(1)));
    out_ready_i = 1'b1;
    tick();
    chk("t2_b_out", 128'(w_obs), 128'(exp_of(2)));
    chk("t2_b_valid", 128'(out_valid_o), 128'(1));
    chk("t2_ready_back", 128'(in_ready_o), 128'(1));
    chk("t2_stall_hold", 128'(stall_cnt_o), 128'(3));
    tick();
    chk("t2_empty", 128'(out_valid_o), 128'(0));

    // Streaming with scoreboard
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    out_ready_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      set_in(100 + i); in_valid_i = 1'b1;
      exp_q.push_back(exp_of(100 + i));
      tick();
      chk("t3_valid", 128'(out_valid_o), 128'(1));
      chk("t3_ready", 128'(in_ready_o), 128'(1));
      chk("t3_data", 128'(w_obs), 128'(exp_q.pop_front()));
    end
    in_valid_i = 1'b0;
    chk("t3_stall0", 128'(stall_cnt_o), 128'(0));
    tick();
    chk("t3_drained", 128'(out_valid_o), 128'(0));

    // Flush while FULL, then flush discarding a same-cycle input
    out_ready_i = 1'b0; set_in(201); in_valid_i = 1'b1;
    tick();
    set_in(202);
    tick();
    chk("t4_full", 128'(state_o), 128'(2));
    set_in(203); flush_i = 1'b1;
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0;
    chk("t4_valid0", 128'(out_valid_o), 128'(0));
    chk("t4_regwrite0", 128'(RegWrite_o), 128'(0));
    chk("t4_ready1", 128'(in_ready_o), 128'(1));
    chk("t4_state_empty", 128'(state_o), 128'(0));
    e = exp_of(201);
    chk("t4_rd_hold", 128'(rd_o), 128'(e[RD_LSB +: 5]));
    out_ready_i = 1'b1;
    set_in(204); in_valid_i = 1'b1; flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t4_flush_in_dropped", 128'(out_valid_o), 128'(0));
    set_in(205);
    tick();
    in_valid_i = 1'b0;
    chk("t4_next_bundle", 128'(w_obs), 128'(exp_of(205)));
    tick();
    chk("t4_no_ghost", 128'(out_valid_o), 128'(0));

    // Stall counter saturation at 15, survives flush
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    out_ready_i = 1'b0; set_in(300); in_valid_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("t5_stall_start", 128'(stall_cnt_o), 128'(0));
    for (int n = 1; n <= 20; n++) begin
      tick();
      chk("t5_stall", 128'(stall_cnt_o), 128'((n > 15) ? 15 : n));
    end
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("t5_stall_after_flush", 128'(stall_cnt_o), 128'(15));
    chk("t5_flushed", 128'(out_valid_o), 128'(0));

    // Reset while FULL overrides flush and handshakes
    set_in(400); in_valid_i = 1'b1;
    tick();
    set_in(401);
    tick();
    chk("t6_full", 128'(state_o), 128'(2));
    rst_i = 1'b1; flush_i = 1'b1; out_ready_i = 1'b1; set_in(402);
    tick();
    rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    chk("t6_valid0", 128'(out_valid_o), 128'(0));
    chk("t6_outputs0", 128'(w_obs), 128'(0));
    chk("t6_stall0", 128'(stall_cnt_o), 128'(0));
    chk("t6_state_empty", 128'(state_o), 128'(0));
    chk("t6_ready1", 128'(in_ready_o), 128'(1));
    tick();
    chk("t6_stay_empty", 128'(out_valid_o), 128'(0));
    chk("t6_ready_stay", 128'(in_ready_o), 128'(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
